lc3_control_unit: RTL and testbench

- Moore-style instruction-sequencing FSM that drives every load, gate, mux-select and memory strobe of the eLC-3 datapath.
- Runs fetch / decode / execute for the supported opcodes.
- Inserts parameterised wait states for synchronous RAM.
- Handles the multiplier Run/Ready handshake and a PAUSE instruction with a Continue handshake.

---
 rtl/lc3_control_unit_if.sv | 35 +++
 rtl/lc3_control_unit.sv | 220 ++++++++++++++++++++++
 tb/tb_lc3_control_unit.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3_control_unit_if.sv
// Control/status bundle between the eLC-3 sequencer and its datapath.
// The master modport is the sequencer; the slave modport is the datapath side.
interface lc3_control_unit_if;
    logic       Run;
    logic       Continue;
    logic [3:0] IR_15_12;
    logic       IR_5;
    logic       IR_11;
    logic       BEN;
    logic       MUL_R;

    logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC;
    logic       GatePC, GateMDR, GateMUL, GateALU, GateMARMUX;
    logic       ADDR1MUX, SR2MUX, MARMUX;
    logic [1:0] ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK;
    logic       MIO_EN, MUL_EN;
    logic       Mem_OE_N, Mem_WE_N;
    logic [4:0] State;

    modport master (
        input  Run, Continue, IR_15_12, IR_5, IR_11, BEN, MUL_R,
        output LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        output GatePC, GateMDR, GateMUL, GateALU, GateMARMUX,
        output ADDR1MUX, SR2MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
        output MIO_EN, MUL_EN, Mem_OE_N, Mem_WE_N, State
    );

    modport slave (
        output Run, Continue, IR_15_12, IR_5, IR_11, BEN, MUL_R,
        input  LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_REG, LD_CC, LD_PC,
        input  GatePC, GateMDR, GateMUL, GateALU, GateMARMUX,
        input  ADDR1MUX, SR2MUX, MARMUX, ADDR2MUX, PCMUX, DRMUX, SR1MUX, ALUK,
        input  MIO_EN, MUL_EN, Mem_OE_N, Mem_WE_N, State
    );
endinterface

// File: rtl/lc3_control_unit.sv
// eLC-3 instruction sequencer: fetch/decode/execute FSM with RAM wait states,
// multiplier handshake and PAUSE/Continue. Outputs are registered from the next state.
module lc3_control_unit #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic                  Clk,
    input  logic                  Reset,
    lc3_control_unit_if.master    bus
);
    localparam int unsigned CNT_W = 3;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT);

    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,  S_FETCH1 = 5'd1,  S_FETCH2  = 5'd2,  S_FETCH3 = 5'd3,
        S_DECODE   = 5'd4,  S_ADD    = 5'd5,  S_AND     = 5'd6,  S_NOT    = 5'd7,
        S_BR_TAKEN = 5'd8,  S_JMP    = 5'd9,  S_JSR1    = 5'd10, S_JSR2   = 5'd11,
        S_LDR1     = 5'd12, S_LDR2   = 5'd13, S_LDR3    = 5'd14, S_STR1   = 5'd15,
        S_STR2     = 5'd16, S_STR3   = 5'd17, S_MUL1    = 5'd18, S_MUL_WAIT = 5'd19,
        S_MUL2     = 5'd20, S_TRAP1  = 5'd21, S_TRAP2   = 5'd22, S_TRAP3  = 5'd23,
        S_TRAP4    = 5'd24, S_PAUSE1 = 5'd25, S_PAUSE2  = 5'd26
    } state_e;

    // RAM strobes kept active-high internally so the idle vector is all zeros.
    typedef struct packed {
        logic       ld_mar, ld_mdr, ld_ir, ld_ben, ld_reg, ld_cc, ld_pc;
        logic       gate_pc, gate_mdr, gate_mul, gate_alu, gate_marmux;
        logic       addr1mux, sr2mux, marmux;
        logic [1:0] addr2mux, pcmux, drmux, sr1mux, aluk;
        logic       mio_en, mul_en, mem_oe, mem_we;
    } ctrl_t;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic             mem_done_c;

    assign mem_done_c = (cnt_q == WAIT_LAST);

    // State, wait counter and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_HALTED;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_HALTED:   if (bus.Run) state_d = S_FETCH1;
            S_FETCH1:   state_d = S_FETCH2;
            S_FETCH2, S_LDR2, S_TRAP3, S_STR3: begin
                if (mem_done_c) begin
                    cnt_d = '0;
                    case (state_q)
                        S_FETCH2: state_d = S_FETCH3;
                        S_LDR2:   state_d = S_LDR3;
                        S_TRAP3:  state_d = S_TRAP4;
                        default:  state_d = S_FETCH1;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_FETCH3:   state_d = S_DECODE;
            S_DECODE: begin
                case (bus.IR_15_12)
                    4'b0001: state_d = S_ADD;
                    4'b0101: state_d = S_AND;
                    4'b1001: state_d = S_NOT;
                    4'b0000: state_d = bus.BEN ? S_BR_TAKEN : S_FETCH1;
                    4'b1100: state_d = S_JMP;
                    4'b0100: state_d = S_JSR1;
                    4'b0110: state_d = S_LDR1;
                    4'b0111: state_d = S_STR1;
                    4'b1000: state_d = S_MUL1;
                    4'b1111: state_d = S_TRAP1;
                    4'b1101: state_d = S_PAUSE1;
                    default: state_d = S_FETCH1;
                endcase
            end
            S_JSR1:     state_d = S_JSR2;
            S_LDR1:     state_d = S_LDR2;
            S_STR1:     state_d = S_STR2;
            S_STR2:     state_d = S_STR3;
            S_MUL1:     state_d = S_MUL_WAIT;
            S_MUL_WAIT: if (bus.MUL_R) state_d = S_MUL2;
            S_TRAP1:    state_d = S_TRAP2;
            S_TRAP2:    state_d = S_TRAP3;
            S_PAUSE1:   if (bus.Continue) state_d = S_PAUSE2;
            S_PAUSE2:   if (!bus.Continue) state_d = S_FETCH1;
            default:    state_d = S_FETCH1;
        endcase
    end

    // Control vector for the state being entered; registered so it lines up with State.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH1: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.ld_mar  = 1'b1;
                ctrl_d.ld_pc   = 1'b1;
            end
            S_FETCH2, S_LDR2, S_TRAP3: begin
                ctrl_d.mem_oe = 1'b1;
                ctrl_d.mio_en = 1'b1;
                ctrl_d.ld_mdr = (cnt_d == WAIT_LAST);
            end
            S_FETCH3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_ir    = 1'b1;
            end
            S_DECODE:   ctrl_d.ld_ben = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
                ctrl_d.sr1mux   = 2'd1;
                ctrl_d.sr2mux   = (state_d != S_NOT) && bus.IR_5;
                ctrl_d.aluk     = (state_d == S_ADD) ? 2'd0 : (state_d == S_AND) ? 2'd1 : 2'd2;
            end
            S_BR_TAKEN: begin
                ctrl_d.addr2mux = 2'd2;
                ctrl_d.pcmux    = 2'd2;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_JMP: begin
                ctrl_d.sr1mux   = 2'd1;
                ctrl_d.addr1mux = 1'b1;
                ctrl_d.pcmux    = 2'd2;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_JSR1, S_TRAP1: begin
                ctrl_d.gate_pc = 1'b1;
                ctrl_d.drmux   = 2'd1;
                ctrl_d.ld_reg  = 1'b1;
            end
            S_JSR2: begin
                ctrl_d.addr1mux = !bus.IR_11;
                ctrl_d.sr1mux   = bus.IR_11 ? 2'd0 : 2'd1;
                ctrl_d.addr2mux = bus.IR_11 ? 2'd3 : 2'd0;
                ctrl_d.pcmux    = 2'd2;
                ctrl_d.ld_pc    = 1'b1;
            end
            S_LDR1, S_STR1: begin
                ctrl_d.sr1mux      = 2'd1;
                ctrl_d.addr1mux    = 1'b1;
                ctrl_d.addr2mux    = 2'd1;
                ctrl_d.marmux      = 1'b1;
                ctrl_d.gate_marmux = 1'b1;
                ctrl_d.ld_mar      = 1'b1;
            end
            S_LDR3: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_STR2: begin
                ctrl_d.aluk     = 2'd3;
                ctrl_d.gate_alu = 1'b1;
                ctrl_d.ld_mdr   = 1'b1;
            end
            S_STR3:     ctrl_d.mem_we = 1'b1;
            S_MUL1, S_MUL_WAIT: begin
                ctrl_d.mul_en = (state_d == S_MUL1);
                ctrl_d.sr1mux = 2'd1;
                ctrl_d.sr2mux = bus.IR_5;
            end
            S_MUL2: begin
                ctrl_d.gate_mul = 1'b1;
                ctrl_d.ld_reg   = 1'b1;
                ctrl_d.ld_cc    = 1'b1;
            end
            S_TRAP2: begin
                ctrl_d.gate_marmux = 1'b1;
                ctrl_d.ld_mar      = 1'b1;
            end
            S_TRAP4: begin
                ctrl_d.gate_mdr = 1'b1;
                ctrl_d.pcmux    = 2'd1;
                ctrl_d.ld_pc    = 1'b1;
            end
            default: ctrl_d = '0;
        endcase
    end

    assign bus.LD_MAR     = ctrl_q.ld_mar;
    assign bus.LD_MDR     = ctrl_q.ld_mdr;
    assign bus.LD_IR      = ctrl_q.ld_ir;
    assign bus.LD_BEN     = ctrl_q.ld_ben;
    assign bus.LD_REG     = ctrl_q.ld_reg;
    assign bus.LD_CC      = ctrl_q.ld_cc;
    assign bus.LD_PC      = ctrl_q.ld_pc;
    assign bus.GatePC     = ctrl_q.gate_pc;
    assign bus.GateMDR    = ctrl_q.gate_mdr;
    assign bus.GateMUL    = ctrl_q.gate_mul;
    assign bus.GateALU    = ctrl_q.gate_alu;
    assign bus.GateMARMUX = ctrl_q.gate_marmux;
    assign bus.ADDR1MUX   = ctrl_q.addr1mux;
    assign bus.SR2MUX     = ctrl_q.sr2mux;
    assign bus.MARMUX     = ctrl_q.marmux;
    assign bus.ADDR2MUX   = ctrl_q.addr2mux;
    assign bus.PCMUX      = ctrl_q.pcmux;
    assign bus.DRMUX      = ctrl_q.drmux;
    assign bus.SR1MUX     = ctrl_q.sr1mux;
    assign bus.ALUK       = ctrl_q.aluk;
    assign bus.MIO_EN     = ctrl_q.mio_en;
    assign bus.MUL_EN     = ctrl_q.mul_en;
    assign bus.Mem_OE_N   = !ctrl_q.mem_oe;
    assign bus.Mem_WE_N   = !ctrl_q.mem_we;
    assign bus.State      = state_q;
endmodule

// File: tb/tb_lc3_control_unit.sv
// Directed self-checking bench for lc3_control_unit with MEM_WAIT = 2.
module tb_lc3_control_unit;
    localparam logic [4:0] ST_HALTED = 5'd0,  ST_FETCH1 = 5'd1,  ST_FETCH2 = 5'd2,
                           ST_FETCH3 = 5'd3,  ST_DECODE = 5'd4,  ST_ADD    = 5'd5,
                           ST_NOT    = 5'd7,  ST_BR_TAKEN = 5'd8, ST_JSR1  = 5'd10,
                           ST_JSR2   = 5'd11, ST_STR1   = 5'd15, ST_STR2   = 5'd16,
                           ST_STR3   = 5'd17, ST_MUL1   = 5'd18, ST_MUL_WAIT = 5'd19,
                           ST_MUL2   = 5'd20, ST_TRAP1  = 5'd21, ST_TRAP2  = 5'd22,
                           ST_TRAP3  = 5'd23, ST_TRAP4  = 5'd24, ST_PAUSE1 = 5'd25,
                           ST_PAUSE2 = 5'd26;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    lc3_control_unit_if bus ();

    lc3_control_unit #(.MEM_WAIT(2)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] loads();
        return {bus.LD_MAR, bus.LD_MDR, bus.LD_IR, bus.LD_BEN, bus.LD_REG, bus.LD_CC, bus.LD_PC};
    endfunction

    // Bus-contention and strobe-exclusivity invariants, every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            check_eq("gate_onehot0",
                     32'($countones({bus.GatePC, bus.GateMDR, bus.GateMUL, bus.GateALU, bus.GateMARMUX}) <= 1), 32'd1);
            check_eq("strobe_excl", 32'(!(!bus.Mem_OE_N && !bus.Mem_WE_N)), 32'd1);
        end
    end

    // Entered with FETCH1 just observed; ends with DECODE observed.
    task automatic fetch_decode(input logic [3:0] op, input logic ir5, input logic ir11, input logic ben);
        bus.IR_15_12 = op;
        bus.IR_5     = ir5;
        bus.IR_11    = ir11;
        bus.BEN      = ben;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("f2_state", 32'(bus.State), 32'(ST_FETCH2));
            check_eq("f2_oe_n", 32'(bus.Mem_OE_N), 32'd0);
            check_eq("f2_mio_en", 32'(bus.MIO_EN), 32'd1);
            check_eq("f2_ld_mdr", 32'(bus.LD_MDR), 32'(i == 2));
        end
        tick();
        check_eq("f3_state", 32'(bus.State), 32'(ST_FETCH3));
        check_eq("f3_ld_ir", 32'({bus.LD_IR, bus.GateMDR}), 32'b11);
        tick();
        check_eq("dec_state", 32'(bus.State), 32'(ST_DECODE));
        check_eq("dec_loads", 32'(loads()), 32'b000_1000);
    endtask

    task automatic expect_fetch1(input string tag);
        check_eq(tag, 32'(bus.State), 32'(ST_FETCH1));
        check_eq({tag, "_ctl"}, 32'({bus.GatePC, bus.LD_MAR, bus.LD_PC, bus.PCMUX}), 32'b111_00);
    endtask

    initial begin
        reset        = 1'b1;
        bus.Run      = 1'b0;
        bus.Continue = 1'b0;
        bus.IR_15_12 = 4'd0;
        bus.IR_5     = 1'b0;
        bus.IR_11    = 1'b0;
        bus.BEN      = 1'b0;
        bus.MUL_R    = 1'b0;
        tick();
        tick();
        check_eq("rst_state", 32'(bus.State), 32'(ST_HALTED));
        check_eq("rst_loads", 32'(loads()), 32'd0);
        check_eq("rst_strobes", 32'({bus.Mem_OE_N, bus.Mem_WE_N}), 32'b11);
        reset = 1'b0;
        tick();
        check_eq("halt_idle", 32'(bus.State), 32'(ST_HALTED));
        bus.Run = 1'b1;
        tick();
        bus.Run = 1'b0;
        expect_fetch1("run_fetch1");

        // ADD R1,R2,#-3 (0x12BD)
        fetch_decode(4'b0001, 1'b1, 1'b0, 1'b0);
        tick();
        check_eq("add_state", 32'(bus.State), 32'(ST_ADD));
        check_eq("add_sel", 32'({bus.SR1MUX, bus.SR2MUX, bus.ALUK}), 32'b01_1_00);
        check_eq("add_ctl", 32'({bus.GateALU, bus.LD_REG, bus.LD_CC}), 32'b111);
        tick();
        expect_fetch1("add_next");

        // BRz not taken
        fetch_decode(4'b0000, 1'b0, 1'b0, 1'b0);
        check_eq("brnt_dec_ldpc", 32'(bus.LD_PC), 32'd0);
        tick();
        expect_fetch1("brnt_next");

        // BRz taken
        fetch_decode(4'b0000, 1'b0, 1'b0, 1'b1);
        tick();
        check_eq("brt_state", 32'(bus.State), 32'(ST_BR_TAKEN));
        check_eq("brt_ctl", 32'({bus.PCMUX, bus.ADDR2MUX, bus.ADDR1MUX, bus.LD_PC}), 32'b10_10_0_1);
        tick();
        expect_fetch1("brt_next");

        // MUL with a slow multiplier
        fetch_decode(4'b1000, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("mul1_state", 32'(bus.State), 32'(ST_MUL1));
        check_eq("mul1_ctl", 32'({bus.MUL_EN, bus.SR1MUX, bus.SR2MUX}), 32'b1_01_0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check_eq("mulw_state", 32'(bus.State), 32'(ST_MUL_WAIT));
            check_eq("mulw_ctl", 32'({bus.MUL_EN, bus.GateMUL, bus.LD_REG, bus.SR1MUX}), 32'b000_01);
        end
        bus.MUL_R = 1'b1;
        tick();
        bus.MUL_R = 1'b0;
        check_eq("mul2_state", 32'(bus.State), 32'(ST_MUL2));
        check_eq("mul2_ctl", 32'({bus.GateMUL, bus.LD_REG, bus.LD_CC, bus.MUL_EN}), 32'b1110);
        tick();
        expect_fetch1("mul_next");
        check_eq("mul_gate_off", 32'(bus.GateMUL), 32'd0);

        // JSR with PC-relative offset
        fetch_decode(4'b0100, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("jsr1_state", 32'(bus.State), 32'(ST_JSR1));
        check_eq("jsr1_ctl", 32'({bus.GatePC, bus.DRMUX, bus.LD_REG}), 32'b1_01_1);
        tick();
        check_eq("jsr2_state", 32'(bus.State), 32'(ST_JSR2));
        check_eq("jsr2_ctl", 32'({bus.ADDR1MUX, bus.ADDR2MUX, bus.PCMUX, bus.LD_PC}), 32'b0_11_10_1);
        tick();
        expect_fetch1("jsr_next");

        // TRAP: vector read with wait states
        fetch_decode(4'b1111, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("trap1_state", 32'(bus.State), 32'(ST_TRAP1));
        tick();
        check_eq("trap2_state", 32'(bus.State), 32'(ST_TRAP2));
        check_eq("trap2_ctl", 32'({bus.MARMUX, bus.GateMARMUX, bus.LD_MAR}), 32'b011);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("trap3_state", 32'(bus.State), 32'(ST_TRAP3));
            check_eq("trap3_ld_mdr", 32'({bus.Mem_OE_N, bus.LD_MDR}), 32'(i == 2));
        end
        tick();
        check_eq("trap4_state", 32'(bus.State), 32'(ST_TRAP4));
        check_eq("trap4_ctl", 32'({bus.GateMDR, bus.PCMUX, bus.LD_PC}), 32'b1_01_1);
        tick();
        expect_fetch1("trap_next");

        // PAUSE with Continue held for 20 cycles
        fetch_decode(4'b1101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("pause1_stall", 32'(bus.State), 32'(ST_PAUSE1));
        end
        bus.Continue = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq("pause2_hold", 32'(bus.State), 32'(ST_PAUSE2));
        end
        bus.Continue = 1'b0;
        tick();
        expect_fetch1("pause_release");
        fetch_decode(4'b1001, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("not_state", 32'(bus.State), 32'(ST_NOT));
        check_eq("not_ctl", 32'({bus.ALUK, bus.SR1MUX, bus.GateALU, bus.LD_REG}), 32'b10_01_11);
        tick();
        expect_fetch1("not_next");
        fetch_decode(4'b1101, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        check_eq("pause_again", 32'(bus.State), 32'(ST_PAUSE1));
        bus.Continue = 1'b1;
        tick();
        bus.Continue = 1'b0;
        tick();
        expect_fetch1("pause_exit");

        // STR, then reset in the middle of the write strobe
        fetch_decode(4'b0111, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("str1_state", 32'(bus.State), 32'(ST_STR1));
        check_eq("str1_ctl", 32'({bus.ADDR1MUX, bus.ADDR2MUX, bus.MARMUX, bus.GateMARMUX, bus.LD_MAR}), 32'b1_01_111);
        tick();
        check_eq("str2_state", 32'(bus.State), 32'(ST_STR2));
        check_eq("str2_ctl", 32'({bus.ALUK, bus.SR1MUX, bus.GateALU, bus.LD_MDR, bus.MIO_EN}), 32'b11_00_110);
        tick();
        check_eq("str3_state", 32'(bus.State), 32'(ST_STR3));
        check_eq("str3_strobes", 32'({bus.Mem_OE_N, bus.Mem_WE_N}), 32'b10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("strrst_state", 32'(bus.State), 32'(ST_HALTED));
        check_eq("strrst_we_n", 32'(bus.Mem_WE_N), 32'd1);
        check_eq("strrst_loads", 32'(loads()), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("post_rst_we_n", 32'({bus.State, bus.Mem_WE_N}), 32'({ST_HALTED, 1'b1}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
